// File: rtl/beta_pkg.sv
// Shared beta core constants: decoder pc_ctrl codes, interrupt FSM states
// and the config register map of the interrupt controller.
package beta_pkg;

  localparam logic [1:0] PC_NORMAL  = 2'd0;
  localparam logic [1:0] PC_ILLEGAL = 2'd2;
  localparam logic [1:0] PC_IRQ     = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2,
    TRAP = 2'd3
  } irq_state_t;

  localparam logic [1:0] CFG_MASK  = 2'd0;
  localparam logic [1:0] CFG_PEND  = 2'd1;
  localparam logic [1:0] CFG_CAUSE = 2'd2;

endpackage

// File: rtl/beta_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module beta_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan from the top so the lowest asserted index is written last.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/beta_irq_ctrl.sv
// Interrupt and supervisor-mode controller: edge-detected sources, mask,
// pending and cause registers, and the irq/sv_bit request FSM.
//   state | meaning
//   IDLE  | user mode, nothing requested
//   REQ   | irq raised for irq_id, waiting for decoder ack
//   SVC   | supervisor mode servicing an interrupt
//   TRAP  | supervisor mode after an illegal-instruction trap
module beta_irq_ctrl
  import beta_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [1:0]         pc_ctrl,
  input  logic               kernel_exit,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq,
  output logic               sv_bit,
  output logic [ID_W-1:0]    irq_id
);

  irq_state_t         state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_vec;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               cause_valid;
  logic               cause_trap;
  logic [ID_W-1:0]    cause_id;
  logic               ack;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  assign rise     = irq_src & ~src_q;
  assign eligible = pending & mask;
  assign ack      = (state == REQ) && (pc_ctrl == PC_IRQ);

  beta_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    clr_vec = '0;
    if (cfg_we && (cfg_addr == CFG_PEND)) clr_vec = cfg_wdata[NUM_SRC-1:0];
    if (ack) clr_vec[irq_id] = 1'b1;
  end

  // A rise is OR-ed in after the clears so a same-cycle set always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      mask    <= '0;
      pending <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr_vec) | rise;
      if (cfg_we && (cfg_addr == CFG_MASK)) mask <= cfg_wdata[NUM_SRC-1:0];
    end
  end

  // Transitions look at the current mask/pending, i.e. before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      irq         <= 1'b0;
      sv_bit      <= 1'b0;
      irq_id      <= '0;
      cause_valid <= 1'b0;
      cause_trap  <= 1'b0;
      cause_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_ctrl == PC_ILLEGAL) begin
            state       <= TRAP;
            sv_bit      <= 1'b1;
            cause_valid <= 1'b1;
            cause_trap  <= 1'b1;
            cause_id    <= '0;
          end else if (win_valid) begin
            state  <= REQ;
            irq    <= 1'b1;
            irq_id <= win_id;
          end
        end
        REQ: begin
          if (ack) begin
            state       <= SVC;
            irq         <= 1'b0;
            sv_bit      <= 1'b1;
            cause_valid <= 1'b1;
            cause_trap  <= 1'b0;
            cause_id    <= irq_id;
          end else if (pc_ctrl == PC_ILLEGAL) begin
            state       <= TRAP;
            irq         <= 1'b0;
            sv_bit      <= 1'b1;
            cause_valid <= 1'b1;
            cause_trap  <= 1'b1;
            cause_id    <= '0;
          end else if (!eligible[irq_id]) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SVC, TRAP: begin
          if (kernel_exit) begin
            state  <= IDLE;
            sv_bit <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          irq    <= 1'b0;
          sv_bit <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK: cfg_rdata[NUM_SRC-1:0] = mask;
      CFG_PEND: cfg_rdata[NUM_SRC-1:0] = pending;
      CFG_CAUSE: begin
        cfg_rdata[31]       = cause_valid;
        cfg_rdata[30]       = cause_trap;
        cfg_rdata[ID_W-1:0] = cause_id;
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_beta_irq_ctrl.sv
// Directed bench for beta_irq_ctrl: entry/exit, priority, masking, trap,
// set-vs-clear collision and mid-service reset.
module tb_beta_irq_ctrl;
  import beta_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_src;
  logic [1:0]  pc_ctrl;
  logic        kernel_exit;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic        sv_bit;
  logic [2:0]  irq_id;

  int checks = 0;
  int errors = 0;

  beta_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .pc_ctrl     (pc_ctrl),
    .kernel_exit (kernel_exit),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .irq         (irq),
    .sv_bit      (sv_bit),
    .irq_id      (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cfg_addr = a;
    #1;
    d = cfg_rdata;
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic chk_out(input string tag, input logic e_irq, input logic e_sv);
    chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
    chk({tag, ".sv"}, 32'(sv_bit), 32'(e_sv));
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; pc_ctrl = PC_NORMAL; kernel_exit = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk_out("rst", 1'b0, 1'b0);
    chk("rst.id", 32'(irq_id), 32'd0);
    chk_reg("rst.mask", CFG_MASK, 32'h0);
    chk_reg("rst.pend", CFG_PEND, 32'h0);
    chk_reg("rst.cause", CFG_CAUSE, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_reg("addr3", 2'd3, 32'h0);

    // basic entry / exit on src[3]
    wr(CFG_MASK, 32'h08);
    chk_reg("b.mask", CFG_MASK, 32'h08);
    irq_src = 8'h08; tick(); irq_src = '0;
    chk_reg("b.pend", CFG_PEND, 32'h08);
    chk_out("b.k", 1'b0, 1'b0);
    tick();
    chk_out("b.k1", 1'b1, 1'b0);
    chk("b.id", 32'(irq_id), 32'd3);
    pc_ctrl = PC_IRQ; tick(); pc_ctrl = PC_NORMAL;
    chk_out("b.ack", 1'b0, 1'b1);
    chk_reg("b.pend0", CFG_PEND, 32'h0);
    chk_reg("b.cause", CFG_CAUSE, 32'h8000_0003);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;
    chk_out("b.exit", 1'b0, 1'b0);
    chk_reg("b.cause_kept", CFG_CAUSE, 32'h8000_0003);

    // priority: src[5] and src[2] together
    wr(CFG_MASK, 32'hFF);
    irq_src = 8'h24; tick(); irq_src = '0;
    chk_reg("p.pend", CFG_PEND, 32'h24);
    tick();
    chk_out("p.req1", 1'b1, 1'b0);
    chk("p.id1", 32'(irq_id), 32'd2);
    pc_ctrl = PC_IRQ; tick(); pc_ctrl = PC_NORMAL;
    chk_reg("p.pend1", CFG_PEND, 32'h20);
    chk_reg("p.cause1", CFG_CAUSE, 32'h8000_0002);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;
    chk_out("p.gap", 1'b0, 1'b0);
    tick();
    chk_out("p.req2", 1'b1, 1'b0);
    chk("p.id2", 32'(irq_id), 32'd5);
    pc_ctrl = PC_IRQ; tick(); pc_ctrl = PC_NORMAL;
    chk_reg("p.pend2", CFG_PEND, 32'h00);
    chk_reg("p.cause2", CFG_CAUSE, 32'h8000_0005);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;

    // masking and withdrawal by W1C
    wr(CFG_MASK, 32'h00);
    irq_src = 8'h02; tick(); irq_src = '0;
    chk_reg("m.pend", CFG_PEND, 32'h02);
    tick(); tick();
    chk_out("m.masked", 1'b0, 1'b0);
    wr(CFG_MASK, 32'h02);
    chk_out("m.wr", 1'b0, 1'b0);
    tick();
    chk_out("m.req", 1'b1, 1'b0);
    chk("m.id", 32'(irq_id), 32'd1);
    wr(CFG_PEND, 32'h02);
    chk_reg("m.w1c", CFG_PEND, 32'h00);
    chk_out("m.w1c_edge", 1'b1, 1'b0);
    tick();
    chk_out("m.withdrawn", 1'b0, 1'b0);
    tick();
    chk_out("m.idle", 1'b0, 1'b0);

    // illegal-op trap with a source arriving during the trap
    wr(CFG_MASK, 32'h01);
    pc_ctrl = PC_ILLEGAL; tick(); pc_ctrl = PC_NORMAL;
    chk_out("t.entry", 1'b0, 1'b1);
    chk_reg("t.cause", CFG_CAUSE, 32'hC000_0000);
    irq_src = 8'h01; tick(); irq_src = '0;
    chk_reg("t.pend", CFG_PEND, 32'h01);
    chk_out("t.hold", 1'b0, 1'b1);
    pc_ctrl = PC_IRQ; tick(); pc_ctrl = PC_NORMAL;
    chk_out("t.ack_ignored", 1'b0, 1'b1);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;
    chk_out("t.exit", 1'b0, 1'b0);
    tick();
    chk_out("t.req", 1'b1, 1'b0);
    chk("t.id", 32'(irq_id), 32'd0);
    pc_ctrl = PC_IRQ; tick(); pc_ctrl = PC_NORMAL;
    chk_reg("t.cause_irq", CFG_CAUSE, 32'h8000_0000);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;

    // rise on src[4] in the same cycle as its ack: set wins
    wr(CFG_MASK, 32'h10);
    irq_src = 8'h10; tick(); irq_src = '0;
    tick();
    chk("c.id", 32'(irq_id), 32'd4);
    irq_src = 8'h10; pc_ctrl = PC_IRQ; tick(); irq_src = '0; pc_ctrl = PC_NORMAL;
    chk_out("c.svc", 1'b0, 1'b1);
    chk_reg("c.pend", CFG_PEND, 32'h10);
    chk_reg("c.cause", CFG_CAUSE, 32'h8000_0004);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;
    // trap beats an eligible source in IDLE
    pc_ctrl = PC_ILLEGAL; tick(); pc_ctrl = PC_NORMAL;
    chk_out("c.trap_wins", 1'b0, 1'b1);
    chk_reg("c.trap_cause", CFG_CAUSE, 32'hC000_0000);
    chk_reg("c.trap_pend", CFG_PEND, 32'h10);
    kernel_exit = 1'b1; tick(); kernel_exit = 1'b0;
    tick();
    chk_out("c.rereq", 1'b1, 1'b0);
    pc_ctrl = PC_IRQ; tick(); pc_ctrl = PC_NORMAL;
    irq_src = 8'h40; tick(); irq_src = '0;
    chk_reg("c.svc_pend", CFG_PEND, 32'h40);

    // reset while in SVC
    reset = 1'b1; tick(); reset = 1'b0;
    chk_out("r", 1'b0, 1'b0);
    chk("r.id", 32'(irq_id), 32'd0);
    chk_reg("r.mask", CFG_MASK, 32'h0);
    chk_reg("r.pend", CFG_PEND, 32'h0);
    chk_reg("r.cause", CFG_CAUSE, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beta_irq_ctrl.md
Name: beta_irq_ctrl

Overview:
Interrupt and supervisor-mode controller for the beta processor; it is the requesting side of the core's irq/sv_bit trap interface.
- Collects edge-triggered peripheral interrupt sources, masks and prioritises them, and raises a single irq to the control decoder.
- Tracks supervisor mode (sv_bit) across interrupt entry, illegal-instruction trap entry and kernel return.
- Exposes mask, pending and cause registers on a small config bus for the kernel handler.

Parameters:
NUM_SRC, 8, number of interrupt source lines (1..32)
ID_W, $clog2(NUM_SRC), width of source id

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
irq_src  in  NUM_SRC  peripheral interrupt lines, rising-edge sensitive, already synchronous to clk
pc_ctrl  in  2  from decoder: 0 normal, 2 illegal-op trap taken, 3 interrupt taken (ack)
kernel_exit  in  1  one-cycle pulse: handler return executed, leave supervisor mode
cfg_we  in  1  config write strobe
cfg_addr  in  2  config register select
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, combinational from cfg_addr
irq  out  1  interrupt request to decoder
sv_bit  out  1  supervisor mode flag to decoder
irq_id  out  ID_W  id of the requested/serviced source

Behaviour:
- Reset: irq=0, sv_bit=0, irq_id=0, MASK=0, PENDING=0, CAUSE=0, src_q=0, state=IDLE. Reset mid-operation (REQ/SVC/TRAP) aborts everything to these values next edge.
- Edge detect: src_q <= irq_src each cycle; rise = irq_src & ~src_q. A rise sets its PENDING bit at the same clock edge.
- Registers:
  - addr0 MASK: RW, bits[NUM_SRC-1:0], 1=enabled.
  - addr1 PENDING: read; write-1-to-clear.
  - addr2 CAUSE: RO, {bit31 valid, bit30 trap, [ID_W-1:0] id}.
  - addr3: reads 0, writes ignored.
  - Unused upper bits read 0.
- Eligible = PENDING & MASK. Priority is fixed: lowest index wins.
- FSM states: IDLE, REQ, SVC, TRAP.
  - IDLE: sv_bit=0, irq=0.
    - pc_ctrl==2 -> TRAP.
    - Else if eligible!=0 -> REQ, latching irq_id = winner.
  - REQ: irq=1, sv_bit=0, irq_id held stable.
    - pc_ctrl==3 -> SVC: clear PENDING[irq_id]; CAUSE={1,0,irq_id}.
    - pc_ctrl==2 -> TRAP; irq drops and PENDING is kept.
    - If PENDING[irq_id]&MASK[irq_id] goes 0 (W1C or mask write) before ack -> IDLE, irq=0 next cycle.
  - SVC: sv_bit=1, irq=0. kernel_exit -> IDLE. pc_ctrl==2/3 are ignored. New rises keep accumulating in PENDING.
  - TRAP: sv_bit=1, irq=0, CAUSE={1,1,0}. kernel_exit -> IDLE.
- Outputs irq, sv_bit and irq_id are registered and reflect state.
- Latency:
  - Rise sampled at edge k -> PENDING set after k -> irq=1 after k+1.
  - After kernel_exit, the earliest re-request is 2 edges later (IDLE for one cycle).
- Simultaneous events:
  - A rise on a bit in the same cycle as its ack-clear or W1C: set wins.
  - pc_ctrl==3 outside REQ is ignored.
  - pc_ctrl==2 and a new eligible source in IDLE: TRAP wins.
  - A cfg write in the same cycle as an FSM transition uses the pre-write MASK/PENDING for that transition.
- CAUSE persists until the next entry. It is never cleared by kernel_exit.

Decomposition:
- Package beta_pkg gains:
  - PC_NORMAL=2'd0, PC_ILLEGAL=2'd2, PC_IRQ=2'd3, shared with the control decoder.
  - Enum irq_state_t {IDLE, REQ, SVC, TRAP}.
  - Config address constants CFG_MASK=0, CFG_PEND=1, CFG_CAUSE=2.
- One sub-module, beta_prio_enc: combinational lowest-index priority encoder (NUM_SRC in -> valid + ID_W id).

Test Plan:
- Basic entry/exit:
  - Stimulus: MASK=0x08, pulse irq_src[3] at edge k.
  - Required: PENDING=0x08 after k; irq=1, irq_id=3 after k+1.
  - pc_ctrl=3 for one cycle -> irq=0, sv_bit=1, PENDING=0, CAUSE=0x8000_0003.
  - kernel_exit -> sv_bit=0.
- Priority:
  - Stimulus: MASK=0xFF, rise on src[5] and src[2] same cycle.
  - Required: irq_id=2; after ack and exit, second request with irq_id=5; PENDING goes 0x24 -> 0x20 -> 0x00.
- Masking:
  - Stimulus: MASK=0, rise src[1].
  - Required: PENDING=0x02, irq stays 0.
  - Write MASK=0x02 -> irq=1 one cycle later.
  - W1C PENDING=0x02 while in REQ -> irq=0 next cycle, state IDLE.
- Trap:
  - Stimulus: pc_ctrl=2 in IDLE.
  - Required: sv_bit=1, CAUSE=0xC000_0000.
  - Rise on masked-in src[0] during TRAP -> irq stays 0 until kernel_exit, then irq=1 two edges later.
- Collision and reset:
  - Stimulus: rise on src[4] in the same cycle as its ack.
  - Required: PENDING[4] remains 1 afterwards.
  - Assert reset while in SVC: next cycle sv_bit=0, irq=0, MASK=0, PENDING=0, CAUSE=0.
